// File: rtl/keypad_pkg.sv
// keypad_pkg: shared FSM encoding, digit width and clog2 helper for the keypad entry block.
package keypad_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, PRESSED = 2'd2, RELEASE = 2'd3} state_t;
   localparam int DIGIT_W = 4;
   function automatic int clog2(input int v);
      for (int r = 0; r < 31; r++) if ((1 << r) >= v) return r;
      return 31;
   endfunction
endpackage

// File: rtl/keypad_entry_if.sv
// keypad_entry_if: encoder inputs, clear and entry outputs of the keypad entry block.
interface keypad_entry_if
   import keypad_pkg::*;
#(
   parameter int NUM_DIGITS = 4
);
   logic                            valid;
   logic [DIGIT_W-1:0]              number;
   logic                            clear;
   logic                            key_strobe;
   logic [DIGIT_W-1:0]              key_code;
   logic [DIGIT_W*NUM_DIGITS-1:0]   digits;
   logic [3:0]                      digit_count;
   logic                            overflow;
   modport master(output valid, number, clear, input key_strobe, key_code, digits, digit_count, overflow);
   modport slave(input valid, number, clear, output key_strobe, key_code, digits, digit_count, overflow);
endinterface

// File: rtl/keypad_debounce.sv
// keypad_debounce: press/release debounce FSM producing one strobe per press.
// Auto-repeat while held is built only when KEYPAD_REPEAT_EN is defined.
module keypad_debounce
   import keypad_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int REPEAT_CYCLES = 16
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               i_valid,
   input  logic [DIGIT_W-1:0] i_number,
   output logic               o_strobe,
   output logic [DIGIT_W-1:0] o_code
);
   localparam int MX = (DEBOUNCE_CYCLES > REPEAT_CYCLES) ? DEBOUNCE_CYCLES : REPEAT_CYCLES;
   localparam int CW = (MX > 1) ? clog2(MX) : 1;
   localparam logic [CW-1:0] D_LAST = CW'(DEBOUNCE_CYCLES - 1);
   state_t             r_state;
   logic [CW-1:0]      r_cnt;
   logic [DIGIT_W-1:0] r_cand;
   logic               r_strobe;
   logic [DIGIT_W-1:0] r_code;
`ifdef KEYPAD_REPEAT_EN
   localparam logic [CW-1:0] R_LAST = CW'(REPEAT_CYCLES - 1);
   logic [CW-1:0]      r_rpt;
`endif
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_cand   <= '0;
         r_strobe <= 1'b0;
         r_code   <= '0;
`ifdef KEYPAD_REPEAT_EN
         r_rpt    <= '0;
`endif
      end else begin
         r_strobe <= 1'b0;
         case (r_state)
            IDLE: if (i_valid) begin
               r_state <= ARM;
               r_cand  <= i_number;
               r_cnt   <= '0;
            end
            ARM: if (!i_valid) r_state <= IDLE;
            else if (i_number != r_cand) begin
               r_cand <= i_number;
               r_cnt  <= '0;
            end else if (r_cnt == D_LAST) begin
               r_state  <= PRESSED;
               r_strobe <= 1'b1;
               r_code   <= r_cand;
`ifdef KEYPAD_REPEAT_EN
               r_rpt    <= '0;
`endif
            end else r_cnt <= r_cnt + 1'b1;
            PRESSED: if (!i_valid) begin
               r_state <= RELEASE;
               r_cnt   <= '0;
            end
`ifdef KEYPAD_REPEAT_EN
            else if (r_rpt == R_LAST) begin
               r_strobe <= 1'b1;
               r_rpt    <= '0;
            end else r_rpt <= r_rpt + 1'b1;
`endif
            // Any return of valid during release is a bounce of the same key.
            RELEASE: if (i_valid) begin
               r_state <= PRESSED;
`ifdef KEYPAD_REPEAT_EN
               r_rpt   <= '0;
`endif
            end else if (r_cnt == D_LAST) r_state <= IDLE;
            else r_cnt <= r_cnt + 1'b1;
            default: r_state <= IDLE;
         endcase
      end
   end
   assign o_strobe = r_strobe;
   assign o_code   = r_code;
endmodule

// File: rtl/keypad_entry.sv
// keypad_entry: debounced keypad digit entry with BCD shift register, digit count and sticky overflow.
// Auto-repeat of a held key is enabled by defining KEYPAD_REPEAT_EN.
module keypad_entry
   import keypad_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int NUM_DIGITS = 4,
   parameter int REPEAT_CYCLES = 16
) (
   input logic           clock,
   input logic           reset_n,
   keypad_entry_if.slave bus
);
   localparam int W = DIGIT_W * NUM_DIGITS;
   localparam logic [3:0] FULL = 4'(NUM_DIGITS);
   logic               w_strobe;
   logic [DIGIT_W-1:0] w_code;
   logic [W-1:0]       r_digits, w_base_digits;
   logic [3:0]         r_count, w_base_count;
   logic               r_overflow, w_base_overflow;
   keypad_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES)
   ) u_debounce (
      .clock,
      .reset_n,
      .i_valid(bus.valid),
      .i_number(bus.number),
      .o_strobe(w_strobe),
      .o_code(w_code)
   );
   // Clear applies first so a same-cycle strobe loads into an emptied register.
   always_comb begin
      w_base_digits   = bus.clear ? '0 : r_digits;
      w_base_count    = bus.clear ? '0 : r_count;
      w_base_overflow = bus.clear ? 1'b0 : r_overflow;
   end
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_digits   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else if (w_strobe) begin
         r_digits   <= W'({w_base_digits, w_code});
         r_count    <= (w_base_count == FULL) ? FULL : w_base_count + 4'd1;
         r_overflow <= w_base_overflow | (w_base_count == FULL);
      end else begin
         r_digits   <= w_base_digits;
         r_count    <= w_base_count;
         r_overflow <= w_base_overflow;
      end
   end
   assign bus.key_strobe  = w_strobe;
   assign bus.key_code    = w_code;
   assign bus.digits      = r_digits;
   assign bus.digit_count = r_count;
   assign bus.overflow    = r_overflow;
endmodule

// File: tb/tb_keypad_entry.sv
// tb_keypad_entry: scoreboard bench; stimulus queues expected strobes, a monitor checks them.
module tb_keypad_entry;
   typedef struct {
      logic [3:0]  code;
      logic [15:0] digits;
      logic [3:0]  cnt;
      logic        ovf;
      int          cyc;
   } exp_t;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;
   exp_t q[$];
   keypad_entry_if #(.NUM_DIGITS(4)) bus();
   keypad_entry #(
      .DEBOUNCE_CYCLES(4),
      .NUM_DIGITS(4),
      .REPEAT_CYCLES(16)
   ) dut (
      .clock(clk),
      .reset_n(rst_n),
      .bus(bus)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic expect_key(input logic [3:0] c, input logic [15:0] d, input logic [3:0] n, input logic o, input int dc);
      exp_t e;
      e.code = c; e.digits = d; e.cnt = n; e.ovf = o; e.cyc = cyc + dc;
      q.push_back(e);
   endtask
   task automatic key(input logic [3:0] c, input logic [15:0] d, input logic [3:0] n, input logic o);
      expect_key(c, d, n, o, 5);
      bus.valid = 1'b1; bus.number = c;
      tick(8);
      bus.valid = 1'b0;
      tick(7);
   endtask
   task automatic chk_zero(input string tag);
      chk({tag, "_strobe"}, 32'(bus.key_strobe), 0);
      chk({tag, "_code"}, 32'(bus.key_code), 0);
      chk({tag, "_digits"}, 32'(bus.digits), 0);
      chk({tag, "_count"}, 32'(bus.digit_count), 0);
      chk({tag, "_overflow"}, 32'(bus.overflow), 0);
   endtask
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && bus.key_strobe) begin
            if (q.size() == 0) chk("unexpected_strobe", 32'(bus.key_code), 32'hFFFF_FFFF);
            else begin
               e = q.pop_front();
               chk("key_code", 32'(bus.key_code), 32'(e.code));
               chk("strobe_cycle", 32'(cyc), 32'(e.cyc));
               @(negedge clk);
               chk("digits", 32'(bus.digits), 32'(e.digits));
               chk("digit_count", 32'(bus.digit_count), 32'(e.cnt));
               chk("overflow", 32'(bus.overflow), 32'(e.ovf));
            end
         end
      end
   end
   initial begin
      bus.valid = 1'b0; bus.number = 4'd0; bus.clear = 1'b0;
      tick(3);
      chk_zero("reset");
      rst_n = 1'b1;
      tick(2);
      // Clean press of 5 held 20 cycles.
      expect_key(4'd5, 16'h0005, 4'd1, 1'b0, 5);
      bus.valid = 1'b1; bus.number = 4'd5;
      tick(20);
      bus.valid = 1'b0;
      tick(8);
      // Press bounce on 3, then stable hold.
      bus.number = 4'd3;
      for (int i = 0; i < 4; i++) begin
         bus.valid = (i % 2 == 0);
         tick(1);
      end
      expect_key(4'd3, 16'h0053, 4'd2, 1'b0, 5);
      bus.valid = 1'b1;
      tick(10);
      bus.valid = 1'b0;
      tick(8);
      // Release bounce on 7 must not re-strobe.
      expect_key(4'd7, 16'h0537, 4'd3, 1'b0, 5);
      bus.valid = 1'b1; bus.number = 4'd7;
      tick(10);
      bus.valid = 1'b0;
      tick(2);
      bus.valid = 1'b1;
      tick(1);
      bus.valid = 1'b0;
      tick(8);
      bus.clear = 1'b1;
      tick(1);
      bus.clear = 1'b0;
      chk("clear1_digits", 32'(bus.digits), 0);
      chk("clear1_count", 32'(bus.digit_count), 0);
      // Overflow: 1,2,3,4,9.
      key(4'd1, 16'h0001, 4'd1, 1'b0);
      key(4'd2, 16'h0012, 4'd2, 1'b0);
      key(4'd3, 16'h0123, 4'd3, 1'b0);
      key(4'd4, 16'h1234, 4'd4, 1'b0);
      key(4'd9, 16'h2349, 4'd4, 1'b1);
      bus.clear = 1'b1;
      tick(1);
      bus.clear = 1'b0;
      chk("clear2_digits", 32'(bus.digits), 0);
      chk("clear2_count", 32'(bus.digit_count), 0);
      chk("clear2_overflow", 32'(bus.overflow), 0);
      key(4'd1, 16'h0001, 4'd1, 1'b0);
      key(4'd2, 16'h0012, 4'd2, 1'b0);
      key(4'd3, 16'h0123, 4'd3, 1'b0);
      key(4'd4, 16'h1234, 4'd4, 1'b0);
      // Clear asserted in the strobe cycle of 8.
      expect_key(4'd8, 16'h0008, 4'd1, 1'b0, 5);
      bus.valid = 1'b1; bus.number = 4'd8;
      tick(5);
      bus.clear = 1'b1;
      tick(1);
      bus.clear = 1'b0;
      tick(2);
      bus.valid = 1'b0;
      tick(7);
      // Reset while pressed, key still held afterwards.
      expect_key(4'd6, 16'h0086, 4'd2, 1'b0, 5);
      bus.valid = 1'b1; bus.number = 4'd6;
      tick(8);
      #2 rst_n = 1'b0;
      #1 chk_zero("async_reset");
      tick(2);
      rst_n = 1'b1;
      expect_key(4'd6, 16'h0006, 4'd1, 1'b0, 5);
      tick(10);
      bus.valid = 1'b0;
      tick(8);
`ifdef KEYPAD_REPEAT_EN
      expect_key(4'd6, 16'h0066, 4'd2, 1'b0, 5);
      expect_key(4'd6, 16'h0666, 4'd3, 1'b0, 21);
      expect_key(4'd6, 16'h6666, 4'd4, 1'b0, 37);
      bus.valid = 1'b1;
      tick(45);
      bus.valid = 1'b0;
      tick(8);
`endif
      tick(5);
      chk("pending_expected", 32'(q.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
